// File: rtl/join_ddp_pkg.sv
// join_ddp shared types: packet layout, field positions and match key.
// Optional sticky drop flag is enabled with JOIN_ERR_EN.
package join_ddp_pkg;

    localparam int PKT_W     = 38;
    localparam int DEST_LSB  = 35;
    localparam int DEST_W    = 3;
    localparam int GEN_LSB   = 27;
    localparam int GEN_W     = 8;
    localparam int NODE_LSB  = 20;
    localparam int NODE_W    = 7;
    localparam int LR_BIT    = 19;
    localparam int JN_BIT    = 18;
    localparam int FLAGS_LSB = 16;
    localparam int FLAGS_W   = 2;
    localparam int DATA_LSB  = 0;
    localparam int DATA_W    = 16;
    localparam int KEY_W     = GEN_W + NODE_W;

    typedef struct packed {
        logic [DEST_W-1:0]  dest;
        logic [GEN_W-1:0]   gen;
        logic [NODE_W-1:0]  node;
        logic               lr;
        logic               jn;
        logic [FLAGS_W-1:0] flags;
        logic [DATA_W-1:0]  data;
    } pkt_t;

    typedef logic [KEY_W-1:0] key_t;

    function automatic key_t key_of(pkt_t p);
        return {p.gen, p.node};
    endfunction

endpackage

// File: rtl/join_ddp_if.sv
// Send(active-low)/Ack(active-high) packet channel.
// master drives Send/PACKET, slave drives Ack.
interface join_ddp_if;
    import join_ddp_pkg::*;

    logic Send;
    logic Ack;
    pkt_t PACKET;

    modport master (output Send, output PACKET, input Ack);
    modport slave  (input Send, input PACKET, output Ack);

endinterface

// File: rtl/join_cam.sv
// Operand matching memory: search by key with opposite LR, lowest index
// wins; insert into lowest free slot; invalidate the hit slot.
module join_cam
    import join_ddp_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  key_t key,
    input  logic lr,
    output logic hit,
    output pkt_t hit_pkt,
    output logic full,
    input  logic ins,
    input  pkt_t ins_pkt,
    input  logic inv
);

    logic [DEPTH-1:0] valid;
    pkt_t             mem [DEPTH];
    logic [IW-1:0]    hit_idx;
    logic [IW-1:0]    free_idx;

    // Scan downward so the lowest matching/free index is the last write.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        full     = &valid;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && key_of(mem[i]) == key && mem[i].lr != lr) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid[i]) free_idx = IW'(i);
        end
        hit_pkt = mem[hit_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (inv) valid[hit_idx] <= 1'b0;
            if (ins) valid[free_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ins) mem[free_idx] <= ins_pkt;
    end

endmodule

// File: rtl/join_ddp.sv
// Join stage: pairs two-operand packets via join_cam, emits left then right
// through a 2-entry queue. ERR port exists only with JOIN_ERR_EN.
module join_ddp
    import join_ddp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic CLK,
    input  logic MR_N,
    join_ddp_if.slave  in_ch,
    join_ddp_if.master out_ch
`ifdef JOIN_ERR_EN
    ,
    output logic ERR
`endif
);

    pkt_t       in_pkt, hit_pkt, left, right;
    pkt_t       q0, q1;
    logic [1:0] cnt;
    logic       send_q, ack_q;
    logic       accept, pop, hit, full, ins, inv, byp;

    assign in_pkt = in_ch.PACKET;
    assign accept = !in_ch.Send && ack_q;
    assign pop    = !send_q && out_ch.Ack;
    assign byp    = accept && !in_pkt.jn;
    assign inv    = accept && in_pkt.jn && hit;
    assign ins    = accept && in_pkt.jn && !hit && !full;

    assign in_ch.Ack     = ack_q;
    assign out_ch.Send   = send_q;
    assign out_ch.PACKET = q0;

    join_cam #(.DEPTH(DEPTH)) u_cam (
        .clk     (CLK),
        .rst_n   (MR_N),
        .key     (key_of(in_pkt)),
        .lr      (in_pkt.lr),
        .hit     (hit),
        .hit_pkt (hit_pkt),
        .full    (full),
        .ins     (ins),
        .ins_pkt (in_pkt),
        .inv     (inv)
    );

    always_comb begin
        left          = in_pkt.lr ? hit_pkt : in_pkt;
        right         = in_pkt.lr ? in_pkt : hit_pkt;
        left[JN_BIT]  = 1'b0;
        right[JN_BIT] = 1'b0;
    end

    // Accepts only happen into an empty queue, so push and pop never collide.
    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            q0     <= '0;
            q1     <= '0;
            cnt    <= 2'd0;
            send_q <= 1'b1;
            ack_q  <= 1'b1;
        end else begin
            unique case (1'b1)
                byp: begin
                    q0     <= in_pkt;
                    cnt    <= 2'd1;
                    send_q <= 1'b0;
                    ack_q  <= 1'b0;
                end
                inv: begin
                    q0     <= left;
                    q1     <= right;
                    cnt    <= 2'd2;
                    send_q <= 1'b0;
                    ack_q  <= 1'b0;
                end
                pop: begin
                    q0  <= q1;
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        send_q <= 1'b1;
                        ack_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef JOIN_ERR_EN
    logic drop;
    assign drop = accept && in_pkt.jn && !hit && full;

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N)     ERR <= 1'b0;
        else if (drop) ERR <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_join_ddp.sv
// Bench for join_ddp: directed cases plus random traffic checked against
// a slot-array matching model and an expected-output queue.
module tb_join_ddp;
    import join_ddp_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic mr_n;
    int   checks = 0;
    int   failures = 0;
    bit   rand_ack = 0;
    logic ack_dir = 1'b1;
`ifdef JOIN_ERR_EN
    logic err;
`endif

    join_ddp_if in_ch();
    join_ddp_if out_ch();

    join_ddp #(.DEPTH(DEPTH)) dut (
        .CLK    (clk),
        .MR_N   (mr_n),
        .in_ch  (in_ch),
        .out_ch (out_ch)
`ifdef JOIN_ERR_EN
        ,
        .ERR    (err)
`endif
    );

    always #5 clk = ~clk;

    pkt_t exp_q[$];
    bit   m_valid [DEPTH];
    pkt_t m_pkt [DEPTH];
    bit   m_err;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic pkt_t mk(input int dest, input int gen, input int node,
                                input int lr, input int jn, input int flags,
                                input int data);
        logic [PKT_W-1:0] v;
        v = '0;
        v[DEST_LSB +: DEST_W]   = DEST_W'(dest);
        v[GEN_LSB +: GEN_W]     = GEN_W'(gen);
        v[NODE_LSB +: NODE_W]   = NODE_W'(node);
        v[LR_BIT]               = lr[0];
        v[JN_BIT]               = jn[0];
        v[FLAGS_LSB +: FLAGS_W] = FLAGS_W'(flags);
        v[DATA_LSB +: DATA_W]   = DATA_W'(data);
        return pkt_t'(v);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        m_err = 0;
    endfunction

    function automatic void model_accept(input pkt_t p);
        int   h;
        int   f;
        pkt_t l;
        pkt_t r;
        h = -1;
        f = -1;
        if (!p.jn) begin
            exp_q.push_back(p);
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (h < 0 && m_valid[i] && m_pkt[i].gen == p.gen &&
                m_pkt[i].node == p.node && m_pkt[i].lr != p.lr) h = i;
            if (f < 0 && !m_valid[i]) f = i;
        end
        if (h >= 0) begin
            m_valid[h] = 0;
            l = p.lr ? m_pkt[h] : p;
            r = p.lr ? p : m_pkt[h];
            l.jn = 1'b0;
            r.jn = 1'b0;
            exp_q.push_back(l);
            exp_q.push_back(r);
        end else if (f >= 0) begin
            m_valid[f] = 1;
            m_pkt[f] = p;
        end else begin
            m_err = 1;
        end
    endfunction

    // Inputs settle at +2 after posedge; mid-cycle values are what the next edge sees.
    always @(posedge clk) begin
        #2;
        out_ch.Ack = rand_ack ? ($urandom_range(0, 3) != 0) : ack_dir;
    end

    always @(negedge clk) begin
        if (!mr_n) begin
            model_reset();
            chk("rst_send_out", 64'(out_ch.Send), 64'(1));
            chk("rst_ack_out", 64'(in_ch.Ack), 64'(1));
            chk("rst_pkt_out", 64'(out_ch.PACKET), 64'(0));
        end else begin
            chk("ack_out", 64'(in_ch.Ack), 64'(exp_q.size() == 0));
            chk("send_out", 64'(out_ch.Send), 64'(exp_q.size() == 0));
            if (exp_q.size() != 0)
                chk("pkt_out", 64'(out_ch.PACKET), 64'(exp_q[0]));
`ifdef JOIN_ERR_EN
            chk("err", 64'(err), 64'(m_err));
`endif
            if (!out_ch.Send && out_ch.Ack && exp_q.size() != 0)
                void'(exp_q.pop_front());
            if (!in_ch.Send && in_ch.Ack)
                model_accept(in_ch.PACKET);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input pkt_t p);
        int n;
        n = 0;
        in_ch.PACKET = p;
        in_ch.Send = 1'b0;
        @(negedge clk);
        while (!in_ch.Ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        in_ch.Send = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 64'(0), 64'(1));
        cyc(1);
    endtask

    task automatic do_reset(input int n);
        mr_n = 1'b0;
        cyc(n);
        chk("rst_send_hold", 64'(out_ch.Send), 64'(1));
        chk("rst_ack_hold", 64'(in_ch.Ack), 64'(1));
        chk("rst_pkt_zero", 64'(out_ch.PACKET), 64'(0));
        mr_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        pkt_t a, b, c, d, l, r, p;
        mr_n = 1'b0;
        in_ch.Send = 1'b1;
        in_ch.PACKET = '0;
        out_ch.Ack = 1'b1;
        cyc(1);
        do_reset(5);

        ack_dir = 1'b1;
        p = mk(7, 0, 1, 0, 0, 0, 4);
        send_pkt(p);
        chk("byp_ack_low", 64'(in_ch.Ack), 64'(0));
        chk("byp_send_low", 64'(out_ch.Send), 64'(0));
        chk("byp_data", 64'(out_ch.PACKET), 64'(p));
        cyc(1);
        chk("byp_ack_back", 64'(in_ch.Ack), 64'(1));
        chk("byp_send_back", 64'(out_ch.Send), 64'(1));

        a = mk(0, 0, 1, 0, 1, 0, 4);
        c = mk(0, 0, 2, 0, 1, 0, 2);
        b = mk(0, 0, 1, 1, 1, 0, 8);
        d = mk(0, 0, 2, 1, 1, 0, 3);
        send_pkt(a);
        cyc(2);
        chk("a_no_out", 64'(out_ch.Send), 64'(1));
        send_pkt(c);
        cyc(2);
        chk("c_no_out", 64'(out_ch.Send), 64'(1));
        send_pkt(b);
        chk("ab_first", 64'(out_ch.PACKET), 64'(mk(0, 0, 1, 0, 0, 0, 4)));
        cyc(1);
        chk("ab_second", 64'(out_ch.PACKET), 64'(mk(0, 0, 1, 1, 0, 0, 8)));
        wait_drain();
        send_pkt(d);
        chk("cd_first", 64'(out_ch.PACKET), 64'(mk(0, 0, 2, 0, 0, 0, 2)));
        cyc(1);
        chk("cd_second", 64'(out_ch.PACKET), 64'(mk(0, 0, 2, 1, 0, 0, 3)));
        wait_drain();

        send_pkt(mk(1, 3, 3, 1, 1, 2, 8));
        cyc(1);
        send_pkt(mk(1, 3, 3, 0, 1, 1, 4));
        chk("rev_left", 64'(out_ch.PACKET), 64'(mk(1, 3, 3, 0, 0, 1, 4)));
        cyc(1);
        chk("rev_right", 64'(out_ch.PACKET), 64'(mk(1, 3, 3, 1, 0, 2, 8)));
        wait_drain();

        ack_dir = 1'b0;
        l = mk(2, 1, 4, 0, 1, 0, 'h11);
        r = mk(2, 1, 4, 1, 1, 0, 'h22);
        send_pkt(l);
        send_pkt(r);
        l.jn = 1'b0;
        r.jn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", 64'(out_ch.PACKET), 64'(l));
            chk("bp_ack_low", 64'(in_ch.Ack), 64'(0));
            cyc(1);
        end
        ack_dir = 1'b1;
        cyc(1);
        chk("bp_right", 64'(out_ch.PACKET), 64'(r));
        chk("bp_right_valid", 64'(out_ch.Send), 64'(0));
        cyc(1);
        chk("bp_empty", 64'(out_ch.Send), 64'(1));

        for (int i = 0; i <= DEPTH; i++) send_pkt(mk(0, 9, 10 + i, 0, 1, 0, i));
        cyc(2);
        chk("ovf_no_out", 64'(out_ch.Send), 64'(1));
`ifdef JOIN_ERR_EN
        chk("ovf_err", 64'(err), 64'(1));
`endif
        send_pkt(mk(0, 9, 10, 1, 1, 0, 'h55));
        chk("ovf_match_l", 64'(out_ch.PACKET), 64'(mk(0, 9, 10, 0, 0, 0, 0)));
        cyc(1);
        chk("ovf_match_r", 64'(out_ch.PACKET), 64'(mk(0, 9, 10, 1, 0, 0, 'h55)));
        wait_drain();
        for (int i = 1; i < DEPTH; i++) begin
            send_pkt(mk(0, 9, 10 + i, 1, 1, 0, 'h100 + i));
            wait_drain();
        end
        do_reset(2);

        rand_ack = 1;
        for (int i = 0; i < 400; i++) begin
            p = mk($urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1),
                   ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                   $urandom_range(0, 65535));
            send_pkt(p);
            cyc($urandom_range(0, 2));
        end
        rand_ack = 0;
        ack_dir = 1'b1;
        wait_drain();

        do_reset(2);
        ack_dir = 1'b0;
        cyc(1);
        send_pkt(mk(0, 2, 5, 0, 1, 0, 1));
        send_pkt(mk(0, 2, 6, 0, 1, 0, 2));
        send_pkt(mk(0, 2, 6, 1, 1, 0, 3));
        cyc(1);
        do_reset(1);
        ack_dir = 1'b1;
        send_pkt(mk(0, 2, 5, 1, 1, 0, 4));
        cyc(2);
        chk("post_rst_no_match", 64'(out_ch.Send), 64'(1));
        send_pkt(mk(0, 2, 5, 0, 1, 0, 7));
        chk("post_rst_l", 64'(out_ch.PACKET), 64'(mk(0, 2, 5, 0, 0, 0, 7)));
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
